// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types and default parameters for the burst memory responder
package mem_resp_pkg;
  localparam int LINE_IDX_W_DEF   = 8;
  localparam int READ_LATENCY_DEF = 4;
  localparam int QUEUE_DEPTH_DEF  = 4;
  typedef logic [1:0] beat_idx_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] stamp;
  } rd_req_t;
  typedef enum logic { R_IDLE, R_BURST } rd_state_t;
endpackage

// File: rtl/burst_req_fifo.sv
// burst_req_fifo: power-of-two deep queue of outstanding read requests
// Ports: push_i/push_data_i enqueue, pop_i dequeues the head,
// count_o is the occupancy (MSB set means full), head_o is the oldest entry.
module burst_req_fifo
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = QUEUE_DEPTH_DEF,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  rd_req_t       push_data_i,
  input  logic          pop_i,
  output logic [CW-1:0] count_o,
  output rd_req_t       head_o
);
  rd_req_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  assign count_d = count_q + CW'(push_i) - CW'(pop_i);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push_i);
      rd_ptr_q <= rd_ptr_q + AW'(pop_i);
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
endmodule

// File: rtl/burst_mem_responder.sv
// burst_mem_responder: 256-bit line memory with 4-beat write/read bursts and fixed read latency
// Ports: mem_addr/mem_read/mem_write/mem_wdata request side, mem_ready acceptance,
// mem_rvalid/mem_raddr/mem_rdata read beats (zero when idle).
module burst_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int LINE_IDX_W   = LINE_IDX_W_DEF,
  parameter int READ_LATENCY = READ_LATENCY_DEF,
  parameter int QUEUE_DEPTH  = QUEUE_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [63:0] mem_wdata,
  output logic        mem_ready,
  output logic        mem_rvalid,
  output logic [31:0] mem_raddr,
  output logic [63:0] mem_rdata
);
  localparam int LINES = 1 << LINE_IDX_W;
  localparam int CW    = $clog2(QUEUE_DEPTH) + 1;
  rd_state_t state_q;
  beat_idx_t rd_beat_q, wr_beat_q;
  logic [LINE_IDX_W-1:0] wr_line_q, wr_line, rd_line;
  logic [15:0] cycle_now_q, age;
  logic [CW-1:0] count;
  logic [3:0][63:0] rd_word;
  rd_req_t head, push_req;
  logic rd_acc, wr_acc, burst, pop, eligible;
  assign mem_ready = !rst && !count[CW-1];
  assign rd_acc    = mem_read && mem_ready && wr_beat_q == '0;
  assign wr_acc    = mem_write && mem_ready && !(mem_read && wr_beat_q == '0);
  assign wr_line   = wr_beat_q == '0 ? mem_addr[LINE_IDX_W+4:5] : wr_line_q;
  assign rd_line   = head.addr[LINE_IDX_W+4:5];
  assign push_req  = '{addr: mem_addr, stamp: cycle_now_q};
  assign burst     = state_q == R_BURST;
  assign pop       = burst && rd_beat_q == 2'd3;
  // Age is taken one cycle ahead because the first beat appears in the cycle after the decision
  assign age       = cycle_now_q + 16'd1 - head.stamp;
  assign eligible  = count != '0 && age >= 16'(READ_LATENCY);
  assign mem_rvalid = burst;
  assign mem_raddr  = burst ? head.addr : '0;
  // Array read is combinational in the beat cycle, so a same-cycle write returns the old word
  assign mem_rdata  = burst ? rd_word[rd_beat_q] : '0;
  burst_req_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (rd_acc),
    .push_data_i(push_req),
    .pop_i      (pop),
    .count_o    (count),
    .head_o     (head)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_now_q <= '0;
      wr_beat_q   <= '0;
    end else begin
      cycle_now_q <= cycle_now_q + 16'd1;
      if (wr_acc) begin
        wr_beat_q <= wr_beat_q + 2'd1;
        wr_line_q <= wr_line;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= R_IDLE;
      rd_beat_q <= '0;
    end else if (state_q == R_IDLE) begin
      if (eligible) begin
        state_q   <= R_BURST;
        rd_beat_q <= '0;
      end
    end else begin
      rd_beat_q <= rd_beat_q + 2'd1;
      if (rd_beat_q == 2'd3) state_q <= R_IDLE;
    end
  end
  for (genvar b = 0; b < 4; b++) begin : g_bank
    logic [63:0] bank_q [LINES];
    always_ff @(posedge clk)
      if (wr_acc && wr_beat_q == 2'(b)) bank_q[wr_line] <= mem_wdata;
    assign rd_word[b] = bank_q[rd_line];
  end
endmodule

// File: tb/tb_burst_mem_responder.sv
// tb_burst_mem_responder: randomized and directed checks against a line-level reference model
module tb_burst_mem_responder;
  localparam int L = 4;
  logic clk = 0, rst = 1, mem_read = 0, mem_write = 0;
  logic [31:0] mem_addr = '0;
  logic [63:0] mem_wdata = '0;
  logic mem_ready, mem_rvalid;
  logic [31:0] mem_raddr;
  logic [63:0] mem_rdata;
  int n_chk = 0, n_fail = 0;
  logic [255:0] line_m [256];
  logic [31:0] qa [$];
  int qs [$];
  int cyc = 0, last_start = -100, wbeat = 0, wline = 0;
  logic exp_ready, burst, rd_acc, wr_acc;
  logic [31:0] exp_raddr;
  logic [63:0] exp_rdata;
  logic [97:0] exp_v;
  wire  [97:0] act_v = {mem_ready, mem_rvalid, mem_raddr, mem_rdata};
  always #5 clk = ~clk;
  burst_mem_responder #(.LINE_IDX_W(8), .READ_LATENCY(L), .QUEUE_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );
  function automatic int idx(logic [31:0] a);
    return int'(a[12:5]);
  endfunction
  task drive(input logic r, input logic w, input logic [31:0] a, input logic [63:0] d);
    mem_read = r; mem_write = w; mem_addr = a; mem_wdata = d;
  endtask
  task eval();
    int k;
    burst = 0; k = 0; exp_raddr = '0; exp_rdata = '0;
    if (qa.size() > 0) begin
      burst = cyc >= qs[0] && cyc <= qs[0] + 3;
      k = cyc - qs[0];
      if (burst) begin
        exp_raddr = qa[0];
        exp_rdata = line_m[idx(qa[0])][64*k +: 64];
      end
    end
    exp_ready = !rst && qa.size() < 4;
    rd_acc = mem_read && exp_ready && wbeat == 0;
    wr_acc = mem_write && exp_ready && !(mem_read && wbeat == 0);
    exp_v = {exp_ready, burst, exp_raddr, exp_rdata};
  endtask
  task tick();
    @(posedge clk);
    if (rst) begin
      qa.delete(); qs.delete(); wbeat = 0; cyc = 0; last_start = -100;
    end else begin
      if (burst && cyc == qs[0] + 3) begin
        void'(qa.pop_front()); void'(qs.pop_front());
      end
      if (wr_acc) begin
        wline = wbeat == 0 ? idx(mem_addr) : wline;
        line_m[wline][64*wbeat +: 64] = mem_wdata;
        wbeat = (wbeat + 1) % 4;
      end
      if (rd_acc) begin
        int s;
        s = (cyc + L > last_start + 5) ? cyc + L : last_start + 5;
        qa.push_back(mem_addr); qs.push_back(s); last_start = s;
      end
      cyc++;
    end
    @(negedge clk);
  endtask
  task test_reset();
    rst = 1; drive(0, 0, '0, '0);
    eval(); tick();
    for (int i = 0; i < 4; i++) begin
      rst = i < 2;
      eval(); #1;
      n_chk++;
      if (act_v !== exp_v) begin n_fail++; $display("FAIL reset i=%0d got %h want %h", i, act_v, exp_v); end
      tick();
    end
    n_chk++;
    if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", mem_ready); end
  endtask
  task test_fill();
    logic [31:0] a;
    for (int ln = 0; ln < 256; ln++)
      for (int bt = 0; bt < 4; bt++) begin
        a = $urandom; a[12:5] = 8'(ln);
        drive(0, 1, a, {$urandom, $urandom});
        eval(); #1;
        n_chk++;
        if (act_v !== exp_v) begin n_fail++; $display("FAIL fill line=%0d got %h want %h", ln, act_v, exp_v); end
        tick();
      end
  endtask
  task test_write_read();
    logic [31:0] a;
    int first = -1;
    for (int i = 0; i < 16; i++) begin
      a = (i == 0 || i == 5) ? 32'h40 : $urandom;
      drive(i == 5, i < 4, a, 64'h1111_1111_1111_1111 * (i + 1));
      eval(); #1;
      n_chk++;
      if (act_v !== exp_v) begin n_fail++; $display("FAIL write_read i=%0d got %h want %h", i, act_v, exp_v); end
      if (mem_rvalid && first < 0) first = i;
      if (i >= 9 && i <= 12) begin
        n_chk++;
        if (!mem_rvalid || mem_raddr !== 32'h40 || mem_rdata !== 64'h1111_1111_1111_1111 * (i - 8)) begin
          n_fail++; $display("FAIL write_read_beat i=%0d got %b/%h/%h want 1/00000040/%h", i, mem_rvalid, mem_raddr, mem_rdata, 64'h1111_1111_1111_1111 * (i - 8));
        end
      end
      tick();
    end
    n_chk++;
    if (first != 9) begin n_fail++; $display("FAIL write_read_latency got %0d want 9", first); end
  endtask
  task test_back_to_back();
    logic on;
    for (int i = 0; i < 25; i++) begin
      drive(i < 4, 0, 32'(i * 32), '0);
      eval(); #1;
      n_chk++;
      if (act_v !== exp_v) begin n_fail++; $display("FAIL b2b i=%0d got %h want %h", i, act_v, exp_v); end
      on = i >= 4 && i <= 22 && (i - 4) % 5 != 4;
      n_chk++;
      if (mem_rvalid !== on || (on && mem_raddr !== 32'((i - 4) / 5 * 32))) begin
        n_fail++; $display("FAIL b2b_sched i=%0d got %b/%h want %b", i, mem_rvalid, mem_raddr, on);
      end
      if (i == 4) begin
        n_chk++;
        if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full got %b want 0", mem_ready); end
      end
      tick();
    end
  endtask
  task test_collision();
    logic [63:0] old0;
    logic [31:0] a;
    old0 = line_m[4][63:0];
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      if (i == 0 || i == 12) a = 32'h80;
      if (i == 8 || i == 13) a = 32'hA0;
      drive(i == 0 || i == 12 || i == 13, i == 0 || (i >= 8 && i <= 11), a, {$urandom, $urandom});
      eval(); #1;
      n_chk++;
      if (act_v !== exp_v) begin n_fail++; $display("FAIL collision i=%0d got %h want %h", i, act_v, exp_v); end
      if (i == 4 || i == 16) begin
        n_chk++;
        if (mem_rdata !== old0) begin n_fail++; $display("FAIL collision_word0 i=%0d got %h want %h", i, mem_rdata, old0); end
      end
      tick();
    end
  endtask
  task test_same_cycle();
    logic [63:0] old2, nw;
    old2 = line_m[2][191:128];
    nw = {$urandom, $urandom};
    for (int i = 0; i < 22; i++) begin
      drive(i == 0 || i == 10, i >= 4 && i <= 7, (i == 0 || i == 4 || i == 10) ? 32'h40 : $urandom,
            i == 6 ? nw : {$urandom, $urandom});
      eval(); #1;
      n_chk++;
      if (act_v !== exp_v) begin n_fail++; $display("FAIL same_cycle i=%0d got %h want %h", i, act_v, exp_v); end
      if (i == 6) begin
        n_chk++;
        if (mem_rdata !== old2) begin n_fail++; $display("FAIL same_cycle_old got %h want %h", mem_rdata, old2); end
      end
      if (i == 16) begin
        n_chk++;
        if (mem_rdata !== nw) begin n_fail++; $display("FAIL same_cycle_new got %h want %h", mem_rdata, nw); end
      end
      tick();
    end
  endtask
  task test_reset_mid_burst();
    logic [31:0] a;
    for (int i = 0; i < 32; i++) begin
      a = $urandom;
      if (i == 0) a = 32'h60;
      if (i == 1) a = 32'h20;
      if (i == 2 || i == 11) a = 32'hC0;
      if (i == 7 || i == 12) a = 32'hE0;
      rst = i == 5;
      drive(i < 2 || i == 11 || i == 12, i == 2 || i == 3 || (i >= 7 && i <= 10), a, {$urandom, $urandom});
      eval(); #1;
      n_chk++;
      if (act_v !== exp_v) begin n_fail++; $display("FAIL rst_mid i=%0d got %h want %h", i, act_v, exp_v); end
      if (i == 6) begin
        n_chk++;
        if (mem_rvalid !== 1'b0 || mem_ready !== 1'b1) begin
          n_fail++; $display("FAIL rst_mid_after got rvalid=%b ready=%b want 0/1", mem_rvalid, mem_ready);
        end
      end
      tick();
    end
  endtask
  task test_random();
    for (int i = 0; i < 3030; i++) begin
      rst = i < 3000 && ($urandom % 400) == 0;
      drive(i < 3000 && ($urandom % 4) == 0, i < 3000 && ($urandom % 3) == 0, $urandom, {$urandom, $urandom});
      eval(); #1;
      n_chk++;
      if (act_v !== exp_v) begin n_fail++; $display("FAIL random i=%0d got %h want %h", i, act_v, exp_v); end
      tick();
    end
  endtask
  task test_wrap();
    int guard = 0, first = -1;
    rst = 0; drive(0, 0, '0, '0);
    while ((cyc % 65536) != 65534 && guard < 70000) begin
      eval(); tick(); guard++;
    end
    n_chk++;
    if (guard >= 70000) begin n_fail++; $display("FAIL wrap_reach got %0d want 65534", cyc % 65536); end
    for (int i = 0; i < 12; i++) begin
      drive(i == 0, 0, $urandom, '0);
      eval(); #1;
      n_chk++;
      if (act_v !== exp_v) begin n_fail++; $display("FAIL wrap i=%0d got %h want %h", i, act_v, exp_v); end
      if (mem_rvalid && first < 0) first = i;
      tick();
    end
    n_chk++;
    if (first != 4) begin n_fail++; $display("FAIL wrap_latency got %0d want 4", first); end
  endtask
  initial begin
    test_reset();
    test_fill();
    test_write_read();
    test_back_to_back();
    test_collision();
    test_same_cycle();
    test_reset_mid_burst();
    test_random();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
